// File: rtl/sctrl_pkg.sv
// sctrl_pkg: shared FSM state type and sctrl register addresses for the sensor controller and its AHB wrapper
package sctrl_pkg;
  typedef enum logic [1:0] {IDLE, SAMPLE, FULL} sctrl_state_t;
  localparam logic [31:0] SCTRL_EN_ADDR    = 32'h3000_0100;
  localparam logic [31:0] SCTRL_CLEAR_ADDR = 32'h3000_0200;
  localparam logic [31:0] SCTRL_DATA_ADDR  = 32'h3000_0300;
endpackage

// File: rtl/sctrl_if.sv
// sctrl_if: wrapper<->controller control/read bus plus the sensor sample handshake
//   master (wrapper/sensor side): drives en, clear, addr, sensor_ready, sensor_out
//   slave  (sensor_ctrl side):    drives sctrl_out, sctrl_interrupt, sensor_en
interface sctrl_if #(parameter int ADDRWIDTH = 6, parameter int DATAWIDTH = 32);
  logic                 sctrl_en;
  logic                 sctrl_clear;
  logic [ADDRWIDTH-1:0] sctrl_addr;
  logic [DATAWIDTH-1:0] sctrl_out;
  logic                 sctrl_interrupt;
  logic                 sensor_ready;
  logic [DATAWIDTH-1:0] sensor_out;
  logic                 sensor_en;
  modport master (output sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
                  input sctrl_out, sctrl_interrupt, sensor_en);
  modport slave  (input sctrl_en, sctrl_clear, sctrl_addr, sensor_ready, sensor_out,
                  output sctrl_out, sctrl_interrupt, sensor_en);
endinterface

// File: rtl/sensor_buf.sv
// sensor_buf: DEPTH x DATAWIDTH register file, one sync write port, one async read port
//   HCLK/HRESETn: clock, async active-low reset (zeroes every entry)
//   we/waddr/wdata: write port; raddr/rdata: combinational read port
module sensor_buf #(
  parameter int ADDRWIDTH = 6,
  parameter int DATAWIDTH = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 we,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [DATAWIDTH-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDRWIDTH;
  logic [DATAWIDTH-1:0] mem [DEPTH];
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we)
      mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sensor_ctrl.sv
// sensor_ctrl: captures sensor samples into a buffer while enabled, interrupts when full
//   HCLK/HRESETn: clock, async active-low reset
//   bus (sctrl_if.slave): enable/clear/read from the wrapper, sample handshake with the sensor
module sensor_ctrl
  import sctrl_pkg::*;
#(
  parameter int ADDRWIDTH = 6,
  parameter int DATAWIDTH = 32
) (
  input logic     HCLK,
  input logic     HRESETn,
  sctrl_if.slave  bus
);
  localparam logic [ADDRWIDTH-1:0] LAST = '1;
  sctrl_state_t         state;
  logic [ADDRWIDTH-1:0] wptr;
  logic                 full;
  logic                 cap;
  // clear gates the request combinationally so a same-cycle sample is dropped
  assign bus.sensor_en       = state == SAMPLE && bus.sctrl_en && !bus.sctrl_clear;
  assign cap                 = bus.sensor_en && bus.sensor_ready;
  assign bus.sctrl_interrupt = full;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= IDLE;
      wptr  <= '0;
      full  <= 1'b0;
    end else if (bus.sctrl_clear) begin
      state <= IDLE;
      wptr  <= '0;
      full  <= 1'b0;
    end else begin
      if (cap) wptr <= wptr + 1'b1;
      if (cap && wptr == LAST) begin
        state <= FULL;
        full  <= 1'b1;
      end else if (state == IDLE && bus.sctrl_en)
        state <= SAMPLE;
      else if (state == SAMPLE && !bus.sctrl_en)
        state <= IDLE;
    end
  sensor_buf #(.ADDRWIDTH(ADDRWIDTH), .DATAWIDTH(DATAWIDTH)) u_buf (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .we      (cap),
    .waddr   (wptr),
    .wdata   (bus.sensor_out),
    .raddr   (bus.sctrl_addr),
    .rdata   (bus.sctrl_out)
  );
endmodule

// File: tb/tb_sensor_ctrl.sv
// tb_sensor_ctrl: directed self-checking bench for sensor_ctrl
module tb_sensor_ctrl;
  typedef struct {
    logic [5:0]  addr;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  vec_t rd_tab [6];
  sctrl_if #(.ADDRWIDTH(6), .DATAWIDTH(32)) bus ();
  sensor_ctrl #(.ADDRWIDTH(6), .DATAWIDTH(32)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
    bus.sctrl_addr = a;
    #1;
    chk(name, bus.sctrl_out, exp);
  endtask
  task automatic capture(input logic [31:0] v);
    bus.sensor_ready = 1'b1;
    bus.sensor_out   = v;
    tick;
    bus.sensor_ready = 1'b0;
  endtask
  initial begin
    int n;
    int c;
    rd_tab[0] = '{6'd0,  32'hA000};
    rd_tab[1] = '{6'd1,  32'hA001};
    rd_tab[2] = '{6'd17, 32'hA011};
    rd_tab[3] = '{6'd31, 32'hA01F};
    rd_tab[4] = '{6'd62, 32'hA03E};
    rd_tab[5] = '{6'd63, 32'hA03F};
    bus.sctrl_en = 0; bus.sctrl_clear = 0; bus.sctrl_addr = 0;
    bus.sensor_ready = 0; bus.sensor_out = 0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    chk("reset_irq", {31'd0, bus.sctrl_interrupt}, 0);
    chk("reset_sensor_en", {31'd0, bus.sensor_en}, 0);
    rd_chk("reset_out", 6'd0, 0);
    // 1: async reset mid-capture at wptr=10
    bus.sctrl_en = 1;
    tick;
    for (int i = 0; i < 10; i++) capture(32'h100 + i);
    rd_chk("pre_reset_data", 6'd3, 32'h103);
    bus.sensor_ready = 1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_irq", {31'd0, bus.sctrl_interrupt}, 0);
    chk("async_reset_sensor_en", {31'd0, bus.sensor_en}, 0);
    for (int a = 0; a < 64; a++) rd_chk("async_reset_buf", 6'(a), 0);
    bus.sctrl_en = 0; bus.sensor_ready = 0;
    tick;
    rst_n = 1'b1;
    tick;
    // 2: full fill, back-to-back
    bus.sctrl_en = 1;
    tick;
    for (int i = 0; i < 64; i++) begin
      bus.sensor_out = 32'hA000 + i;
      bus.sensor_ready = 1;
      #1;
      chk("fill_sensor_en", {31'd0, bus.sensor_en}, 1);
      if (i == 63) chk("fill_irq_early", {31'd0, bus.sctrl_interrupt}, 0);
      tick;
    end
    bus.sensor_ready = 0;
    chk("fill_irq", {31'd0, bus.sctrl_interrupt}, 1);
    chk("fill_sensor_en_off", {31'd0, bus.sensor_en}, 0);
    bus.sensor_ready = 1;
    tick;
    bus.sensor_ready = 0;
    chk("full_irq_hold", {31'd0, bus.sctrl_interrupt}, 1);
    chk("full_sensor_en_off", {31'd0, bus.sensor_en}, 0);
    for (int i = 0; i < 6; i++) rd_chk("fill_read", rd_tab[i].addr, rd_tab[i].exp);
    // 5: rearm and second fill
    bus.sctrl_clear = 1;
    tick;
    bus.sctrl_clear = 0;
    chk("rearm_irq_low", {31'd0, bus.sctrl_interrupt}, 0);
    rd_chk("rearm_old_data", 6'd5, 32'hA005);
    tick;
    for (int i = 0; i < 64; i++) capture(32'hB000 + i);
    chk("refill_irq", {31'd0, bus.sctrl_interrupt}, 1);
    rd_chk("refill_data5", 6'd5, 32'hB005);
    rd_chk("refill_data63", 6'd63, 32'hB03F);
    // 3: gaps and pause after 20 captures
    bus.sctrl_en = 0; bus.sctrl_clear = 1;
    tick;
    bus.sctrl_clear = 0; bus.sctrl_en = 1;
    tick;
    n = 0; c = 0;
    while (n < 20) begin
      bus.sensor_ready = c[0];
      bus.sensor_out = 32'hC000 + n;
      tick;
      if (c[0]) n++;
      c++;
    end
    bus.sctrl_en = 0;
    bus.sensor_ready = 1;
    bus.sensor_out = 32'h0BAD;
    #1;
    chk("pause_sensor_en", {31'd0, bus.sensor_en}, 0);
    tick; tick;
    bus.sensor_ready = 0;
    bus.sctrl_en = 1;
    tick;
    c = 0;
    while (n < 30) begin
      bus.sensor_ready = c[0];
      bus.sensor_out = 32'hC000 + n;
      tick;
      if (c[0]) n++;
      c++;
    end
    bus.sensor_ready = 0;
    for (int k = 0; k < 30; k++) rd_chk("pause_data", 6'(k), 32'hC000 + k);
    rd_chk("pause_untouched", 6'd30, 32'hB01E);
    // 4: clear beats a same-cycle capture at wptr=5
    bus.sctrl_en = 0; bus.sctrl_clear = 1;
    tick;
    bus.sctrl_clear = 0; bus.sctrl_en = 1;
    tick;
    for (int i = 0; i < 5; i++) capture(32'hD000 + i);
    bus.sctrl_clear = 1;
    bus.sensor_ready = 1;
    bus.sensor_out = 32'hEEEE;
    #1;
    chk("clear_sensor_en", {31'd0, bus.sensor_en}, 0);
    tick;
    bus.sctrl_clear = 0; bus.sensor_ready = 0;
    rd_chk("clear_drop", 6'd5, 32'hC005);
    chk("clear_irq", {31'd0, bus.sctrl_interrupt}, 0);
    tick;
    capture(32'hF000);
    rd_chk("clear_wptr0", 6'd0, 32'hF000);
    rd_chk("clear_idx1_kept", 6'd1, 32'hD001);
    // 6: read/write collision at wptr=3
    capture(32'hF001);
    capture(32'hF002);
    bus.sctrl_addr = 6'd3;
    bus.sensor_out = 32'hDEAD;
    bus.sensor_ready = 1;
    #1;
    chk("collide_old", bus.sctrl_out, 32'hD003);
    tick;
    bus.sensor_ready = 0;
    #1;
    chk("collide_new", bus.sctrl_out, 32'hDEAD);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
